// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB-Lite encodings and arbiter state type shared by the master arbiter
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_t;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    typedef enum logic [1:0] {
        ARB_PARK   = 2'd0,
        ARB_OWNED  = 2'd1,
        ARB_LOCKED = 2'd2
    } arb_state_t;

    // Zero means an undefined-length INCR burst, which never ends by count.
    function automatic logic [4:0] burst_beats(input hburst_t b);
        case (b)
            HBURST_SINGLE:                return 5'd1;
            HBURST_WRAP4, HBURST_INCR4:   return 5'd4;
            HBURST_WRAP8, HBURST_INCR8:   return 5'd8;
            HBURST_WRAP16, HBURST_INCR16: return 5'd16;
            default:                      return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot picker searching from ptr+1 upward with wrap
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    always_comb begin
        int cand;
        cand  = 0;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        // The previous winner is visited last, so it only keeps the bus when alone.
        for (int k = 1; k <= N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/ahb_master_arbiter.sv
// rtl/ahb_master_arbiter.sv - round-robin AHB-Lite master arbiter with burst and lock handling
module ahb_master_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int PARK_MASTER = 0,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_MASTERS-1:0]          m_hbusreq,
    input  logic [NUM_MASTERS-1:0]          m_hlock,
    input  logic [2*NUM_MASTERS-1:0]        m_htrans,
    input  logic [ADDR_W*NUM_MASTERS-1:0]   m_haddr,
    input  logic [NUM_MASTERS-1:0]          m_hwrite,
    input  logic [3*NUM_MASTERS-1:0]        m_hsize,
    input  logic [3*NUM_MASTERS-1:0]        m_hburst,
    input  logic [4*NUM_MASTERS-1:0]        m_hprot,
    input  logic [DATA_W*NUM_MASTERS-1:0]   m_hwdata,
    output logic [NUM_MASTERS-1:0]          m_hgrant,
    output logic [$clog2(NUM_MASTERS)-1:0]  m_hmaster,
    output logic [DATA_W-1:0]               m_hrdata,
    output logic [1:0]                      m_hresp,
    output logic                            HSEL,
    output logic [ADDR_W-1:0]               HADDR,
    output logic [1:0]                      HTRANS,
    output logic                            HWRITE,
    output logic [2:0]                      HSIZE,
    output logic [2:0]                      HBURST,
    output logic [3:0]                      HPROT,
    output logic [DATA_W-1:0]               HWDATA,
    output logic                            HREADY,
    input  logic                            HREADYOUT,
    input  logic [DATA_W-1:0]               HRDATA,
    input  logic [1:0]                      HRESP
);

    localparam int IW = $clog2(NUM_MASTERS);
    localparam logic [IW-1:0]          PARK_IDX   = IW'(PARK_MASTER);
    localparam logic [NUM_MASTERS-1:0] PARK_GRANT = NUM_MASTERS'(1) << PARK_MASTER;

    arb_state_t       state;
    logic [IW-1:0]    grant_idx;
    logic [IW-1:0]    addr_owner;
    logic [IW-1:0]    data_owner;
    logic [IW-1:0]    rr_ptr;
    logic [4:0]       beat_cnt;

    logic [NUM_MASTERS-1:0] win_grant;
    logic [IW-1:0]          win_idx;
    logic                   win_valid;

    htrans_t trans;
    hburst_t burst;
    logic    own_addr;
    logic    other_req;
    logic    last_beat;
    logic    idle_release;
    logic    err_release;
    logic    release_grant;
    logic    arb_now;

    rr_arbiter #(.N(NUM_MASTERS), .IW(IW)) u_rr (
        .req   (m_hbusreq),
        .ptr   (rr_ptr),
        .grant (win_grant),
        .idx   (win_idx),
        .valid (win_valid)
    );

    assign HSEL      = 1'b1;
    assign HREADY    = HREADYOUT;
    assign m_hrdata  = HRDATA;
    assign m_hresp   = HRESP;
    assign m_hmaster = addr_owner;

    assign HADDR  = m_haddr[ADDR_W*int'(addr_owner) +: ADDR_W];
    assign HTRANS = m_htrans[2*int'(addr_owner) +: 2];
    assign HWRITE = m_hwrite[addr_owner];
    assign HSIZE  = m_hsize[3*int'(addr_owner) +: 3];
    assign HBURST = m_hburst[3*int'(addr_owner) +: 3];
    assign HPROT  = m_hprot[4*int'(addr_owner) +: 4];
    assign HWDATA = m_hwdata[DATA_W*int'(data_owner) +: DATA_W];

    assign trans = htrans_t'(HTRANS);
    assign burst = hburst_t'(HBURST);

    // Transfer-based release only applies once the granted master really drives the address bus;
    // during the handover cycle the previous owner's bubble must not be mistaken for the new owner's.
    assign own_addr     = (addr_owner == grant_idx);
    assign other_req    = |(m_hbusreq & ~m_hgrant);
    assign last_beat    = own_addr &&
                          ((trans == HTRANS_NONSEQ && burst_beats(burst) == 5'd1) ||
                           (trans == HTRANS_SEQ && beat_cnt == 5'd2));
    assign idle_release = own_addr && (trans == HTRANS_IDLE) && other_req;
    assign err_release  = (data_owner == grant_idx) && (HRESP == HRESP_ERROR);
    assign release_grant = !m_hbusreq[grant_idx] || last_beat || idle_release || err_release;

    always_comb begin
        arb_now = 1'b0;
        case (state)
            ARB_PARK:   arb_now = 1'b1;
            ARB_OWNED:  arb_now = release_grant;
            ARB_LOCKED: arb_now = !m_hlock[grant_idx];
            default:    arb_now = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ARB_PARK;
            m_hgrant   <= PARK_GRANT;
            grant_idx  <= PARK_IDX;
            addr_owner <= PARK_IDX;
            data_owner <= PARK_IDX;
            rr_ptr     <= '0;
            beat_cnt   <= '0;
        end else if (HREADYOUT) begin
            addr_owner <= grant_idx;
            data_owner <= addr_owner;

            if (HRESP == HRESP_ERROR)
                beat_cnt <= '0;
            else if (own_addr && trans == HTRANS_NONSEQ)
                beat_cnt <= burst_beats(burst);
            else if (own_addr && trans == HTRANS_SEQ && beat_cnt > 5'd1)
                beat_cnt <= beat_cnt - 5'd1;

            if (arb_now) begin
                if (win_valid) begin
                    m_hgrant  <= win_grant;
                    grant_idx <= win_idx;
                    rr_ptr    <= win_idx;
                    state     <= m_hlock[win_idx] ? ARB_LOCKED : ARB_OWNED;
                end else begin
                    m_hgrant  <= PARK_GRANT;
                    grant_idx <= PARK_IDX;
                    state     <= ARB_PARK;
                end
            end
        end
    end

endmodule
